// File: rtl/imem_fetch_resp.sv
// Instruction-memory responder: loaded through a word-write port, then serves PC fetches
// through a LAT-stage flushable read pipeline. Define IMEM_PARITY_EN for per-word parity.
module imem_fetch_resp #(
   parameter int              AW        = 16,
   parameter int              DW        = 9,
   parameter int              IDXW      = 8,
   parameter int              LAT       = 2,
   parameter logic [DW-1:0]   HALT_WORD = 9'h1FF
) (
   input  logic               clk,
   input  logic               Init_n,
   input  logic [AW-1:0]      PC,
   input  logic               fetch_en,
   input  logic               flush,
   input  logic               ld_en,
   input  logic [IDXW-1:0]    ld_addr,
   input  logic [DW-1:0]      ld_data,
   input  logic               ld_done,
`ifdef IMEM_PARITY_EN
   input  logic               ld_par_flip,
   output logic               par_err,
`endif
   output logic               run,
   output logic [DW-1:0]      instr_out,
   output logic               instr_valid,
   output logic [AW-1:0]      instr_pc,
   output logic               oob,
   output logic               ld_err
);

   localparam int DEPTH = 1 << IDXW;
`ifdef IMEM_PARITY_EN
   localparam int MW = DW + 1;
`else
   localparam int MW = DW;
`endif

   typedef enum logic {S_LOAD, S_RUN} state_t;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic          oob;
      logic [DW-1:0] word;
`ifdef IMEM_PARITY_EN
      logic          perr;
`endif
   } resp_t;

   state_t        state, state_nx;
   logic [MW-1:0] mem [DEPTH];
   logic [MW-1:0] rd;
   resp_t         s0;
   resp_t         pipe [1:LAT];
   logic [LAT:1]  vld_pipe;
   logic          issue;

   // ---------------- mode FSM ----------------
   always_ff @(posedge clk or negedge Init_n) begin
      if (!Init_n) state <= S_LOAD;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (state == S_LOAD && ld_done) state_nx = S_RUN;
   end

   assign run = (state == S_RUN);

   always_ff @(posedge clk or negedge Init_n) begin
      if (!Init_n)          ld_err <= 1'b0;
      else if (run && ld_en) ld_err <= 1'b1;
   end

   // ---------------- program store (never reset) ----------------
   always_ff @(posedge clk) begin
`ifdef IMEM_PARITY_EN
      if (!run && ld_en) mem[ld_addr] <= {(^ld_data) ^ ld_par_flip, ld_data};
`else
      if (!run && ld_en) mem[ld_addr] <= ld_data;
`endif
   end

   // ---------------- stage-1 lookup ----------------
   assign issue = run & fetch_en;

   always_comb begin
      rd      = mem[PC[IDXW-1:0]];
      s0      = '0;
      s0.pc   = PC;
      s0.oob  = |PC[AW-1:IDXW];
      s0.word = s0.oob ? HALT_WORD : rd[DW-1:0];
`ifdef IMEM_PARITY_EN
      s0.perr = !s0.oob && ((^rd[DW-1:0]) != rd[DW]);
`endif
   end

   // Payload only advances with a live valid bit, so the last stage holds between responses.
   // Flush masks every stage-to-stage move but never the new issue (the branch target).
   always_ff @(posedge clk or negedge Init_n) begin
      if (!Init_n) begin
         vld_pipe <= '0;
         for (int k = 1; k <= LAT; k++) pipe[k] <= '0;
      end else begin
         vld_pipe[1] <= issue;
         if (issue) pipe[1] <= s0;
         for (int k = 2; k <= LAT; k++) begin
            vld_pipe[k] <= vld_pipe[k-1] & ~flush;
            if (vld_pipe[k-1] && !flush) pipe[k] <= pipe[k-1];
         end
      end
   end

   assign instr_valid = vld_pipe[LAT];
   assign instr_out   = pipe[LAT].word;
   assign instr_pc    = pipe[LAT].pc;
   assign oob         = pipe[LAT].oob;
`ifdef IMEM_PARITY_EN
   assign par_err     = pipe[LAT].perr;
`endif

endmodule

// File: tb/tb_imem_fetch_resp.sv
// Randomised bench for imem_fetch_resp against a queue-based transaction model.
module tb_imem_fetch_resp;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        Init_n;
   logic [15:0] PC;
   logic        fetch_en, flush, ld_en, ld_done, ld_par_flip;
   logic [7:0]  ld_addr;
   logic [8:0]  ld_data;
   logic        run, instr_valid, oob, ld_err;
   logic [8:0]  instr_out;
   logic [15:0] instr_pc;
`ifdef IMEM_PARITY_EN
   logic        par_err;
`endif

   imem_fetch_resp #(.LAT(LAT)) dut (
      .clk(clk), .Init_n(Init_n), .PC(PC), .fetch_en(fetch_en), .flush(flush),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
`ifdef IMEM_PARITY_EN
      .ld_par_flip(ld_par_flip), .par_err(par_err),
`endif
      .run(run), .instr_out(instr_out), .instr_valid(instr_valid),
      .instr_pc(instr_pc), .oob(oob), .ld_err(ld_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { logic [15:0] pc; int due; } pend_t;
   pend_t       pend[$];
   logic [8:0]  mem_m  [256];
   logic        flip_m [256];
   logic        m_run, m_err;
   logic [8:0]  h_word;
   logic [15:0] h_pc;
   logic        h_oob, h_perr;
   int          edge_n = 0;

   task automatic model_reset();
      pend.delete();
      m_run = 0; m_err = 0;
      h_word = '0; h_pc = '0; h_oob = 0; h_perr = 0;
   endtask

   task automatic step();
      logic exp_v;
      pend_t e;
      @(posedge clk);
      edge_n++;
      exp_v = 0;
      if (flush) pend.delete();
      if (m_run && fetch_en) pend.push_back('{pc: PC, due: edge_n + LAT - 1});
      if (pend.size() > 0 && pend[0].due == edge_n) begin
         e      = pend.pop_front();
         exp_v  = 1;
         h_pc   = e.pc;
         h_oob  = (e.pc >= 16'd256);
         h_word = h_oob ? 9'h1FF : mem_m[e.pc[7:0]];
         h_perr = !h_oob && flip_m[e.pc[7:0]];
      end
      if (!m_run && ld_en) begin
         mem_m[ld_addr]  = ld_data;
         flip_m[ld_addr] = ld_par_flip;
      end
      if (m_run && ld_en) m_err = 1;
      if (!m_run && ld_done) m_run = 1;
      #1;
      chk("valid",  instr_valid, exp_v);
      chk("instr",  instr_out,   h_word);
      chk("pc",     instr_pc,    h_pc);
      chk("oob",    oob,         h_oob);
      chk("run",    run,         m_run);
      chk("ld_err", ld_err,      m_err);
`ifdef IMEM_PARITY_EN
      if (exp_v) chk("par_err", par_err, h_perr);
`endif
   endtask

   task automatic idle();
      fetch_en = 0; flush = 0; ld_en = 0; ld_done = 0; ld_par_flip = 0;
   endtask

   task automatic fetch(input logic [15:0] a, input logic fl);
      idle(); fetch_en = 1; PC = a; flush = fl;
      step();
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < LAT + 1; i++) step();
   endtask

   logic [8:0] init_words [4];

   initial begin
      init_words[0] = 9'h011; init_words[1] = 9'h022;
      init_words[2] = 9'h033; init_words[3] = 9'h044;
      for (int i = 0; i < 256; i++) begin mem_m[i] = 'x; flip_m[i] = 0; end
      Init_n = 0; PC = 0; ld_addr = 0; ld_data = 0;
      idle();
      model_reset();
      #3;
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr_out,   0);
      chk("rst_pc",    instr_pc,    0);
      chk("rst_oob",   oob,         0);
      chk("rst_run",   run,         0);
      chk("rst_ld_err", ld_err,     0);
      @(posedge clk); #1; Init_n = 1;

      // fetches in LOAD are ignored
      for (int i = 0; i < 5; i++) begin
         idle(); fetch_en = 1; PC = 16'($urandom_range(0, 255));
         step();
      end

      // load every word; final write coincides with ld_done
      for (int i = 0; i < 256; i++) begin
         idle();
         ld_en = 1; ld_addr = 8'(i);
         ld_data = (i < 4) ? init_words[i] : 9'($urandom);
         ld_par_flip = (i == 5) ? 1'b1 : (i == 4) ? 1'b0 : 1'($urandom_range(0, 3) == 0);
         fetch_en = 1; PC = 16'(i);
         ld_done = (i == 255);
         step();
      end

      // directed: sequential fetch, out of range, flush with branch target
      for (int i = 0; i < 4; i++) fetch(16'(i), 0);
      drain();
      fetch(16'h0100, 0);
      drain();
      fetch(16'd0, 0); fetch(16'd1, 0); fetch(16'd3, 1);
      drain();

      // load attempt in RUN: sticky error, memory untouched
      idle(); ld_en = 1; ld_addr = 0; ld_data = 9'h0AA; ld_done = 1;
      step();
      fetch(16'd0, 0);
      drain();
      fetch(16'd5, 0); fetch(16'd4, 0);
      drain();

      // randomised traffic
      for (int i = 0; i < 400; i++) begin
         idle();
         fetch_en = ($urandom_range(0, 9) < 7);
         flush    = ($urandom_range(0, 9) == 0);
         ld_en    = ($urandom_range(0, 49) == 0);
         PC       = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
         step();
      end

      // reset with reads in flight
      fetch(16'd1, 0); fetch(16'd2, 0);
      idle();
      #2 Init_n = 0;
      model_reset();
      #1;
      chk("mid_rst_valid", instr_valid, 0);
      chk("mid_rst_run",   run,         0);
      chk("mid_rst_instr", instr_out,   0);
      chk("mid_rst_err",   ld_err,      0);
      @(posedge clk); #1; Init_n = 1;
      drain();
      idle(); ld_done = 1;
      step();
      for (int i = 0; i < 6; i++) fetch(16'(i), 0);
      for (int i = 0; i < 60; i++) begin
         idle();
         fetch_en = $urandom_range(0, 1);
         flush    = ($urandom_range(0, 7) == 0);
         PC       = 16'($urandom_range(0, 300));
         step();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
